instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Front end of the single-issue CPU: holds the PC and fetches words from instruction memory over a request/response handshake.
- Presents one instruction per slot to the instruction decoder.
- Consumes the decoder-encoded branch controls (BS, PS) plus the Z flag from execute, and redirects the PC on taken branches and jumps.
- Drives NOP (all-zero word) whenever no valid instruction is present, so the decoder needs no valid input.

Parameters:
- INSTRUCTION_SIZE, 32, instruction word width.
- ADDR_WIDTH, 32, PC / word-address width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_WIDTH  word address; stable while imem_req is high.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  INSTRUCTION_SIZE  response word.
- instruction  out  INSTRUCTION_SIZE  word to decoder; 0 (NOP) when instr_valid=0.
- instr_valid  out  1  instruction/instr_pc meaningful.
- instr_pc  out  ADDR_WIDTH  address of the presented instruction.
- stall  in  1  decode not accepting; hold outputs.
- ex_valid  in  1  ex_bs/ex_ps/ex_pc/ex_imm/ex_reg_a come from a real instruction.
- ex_bs  in  2  00 next, 01 conditional branch, 10 jump-register, 11 jump.
- ex_ps  in  1  0 = branch on Z, 1 = branch on !Z.
- ex_z  in  1  zero flag of the branch instruction's ALU result.
- ex_pc  in  ADDR_WIDTH  PC of the branching instruction.
- ex_imm  in  ADDR_WIDTH  sign-extended offset.
- ex_reg_a  in  ADDR_WIDTH  register A value (JMR target).

Behaviour:
- Reset values: pc=RESET_PC, state=START, imem_req=0, imem_addr=RESET_PC, instruction=0, instr_valid=0, instr_pc=0.
- Redirect: asserted when ex_valid and one of
  - ex_bs=01 with (ex_z XOR ex_ps)=1, target = ex_pc+1+ex_imm;
  - ex_bs=10, target = ex_reg_a;
  - ex_bs=11, target = ex_pc+1+ex_imm.
- ex_bs=00, a not-taken branch, or ex_valid=0 produces no redirect.
- All PC arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
- States:
  - START: one cycle, then REQ.
  - REQ: imem_req=1, imem_addr=pc.
    - imem_ready=1 -> WAIT, pc<=pc+1.
    - Redirect in REQ has priority: pc<=target, stay in REQ, and the request is withdrawn/re-aimed. An accept in the same cycle is treated as a request to be dropped -> DROP.
  - WAIT: on imem_rvalid, instruction<=imem_rdata, instr_pc<=pc-1, instr_valid<=1 the next cycle, go to HOLD.
    - Redirect before or with rvalid -> DROP (or straight to REQ if rvalid arrives in the same cycle), pc<=target, response discarded.
  - DROP: wait for the outstanding imem_rvalid, discard the data, then REQ. Redirects here only update pc.
  - HOLD: outputs frozen while stall=1.
    - stall=0: the instruction is consumed that cycle; instr_valid<=0 and instruction<=0 next cycle, then REQ.
    - Redirect: invalidate the held instruction next cycle, pc<=target, then REQ.
- At most one fetch outstanding at any time.
- imem_rvalid outside WAIT/DROP is ignored (e.g. a stale response after reset).
- Minimum throughput: one instruction per 3 cycles with a zero-wait memory. No prefetch beyond one outstanding request.
- Latency: REQ accepted in cycle N, rvalid in N+k, instr_valid high from N+k+1.
- Reset asserted mid-operation returns everything to reset values immediately; no partial state survives.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants;
  - BS encodings (BS_NEXT=2'b00, BS_BRANCH=2'b01, BS_JMR=2'b10, BS_JUMP=2'b11);
  - NOP word;
  - fetch state enum (START, REQ, WAIT, DROP, HOLD).
- One combinational sub-module, next_pc_unit: takes ex_* and pc, returns redirect and target.

Test Plan:
- Reset release, RESET_PC=0, imem_ready=1, rvalid one cycle after accept, data 0x04420000 -> requests at 0,1,2; instruction=0x04420000 with instr_pc=0, and instruction=0 between slots.
- stall=1 for 4 cycles with an instruction at pc 5 held -> instruction/instr_pc stable, imem_req=0, next request to 6 only after stall drops.
- ex_bs=01, ex_ps=0, ex_z=1, ex_pc=10, ex_imm=-3 during WAIT -> response discarded, next imem_addr=8, no instruction from the old fetch reaches the output.
- ex_bs=01, ex_ps=1, ex_z=1 -> no redirect, sequential fetch continues; ex_bs=10, ex_reg_a=0x40 during HOLD -> instr_valid=0 next cycle, next imem_addr=0x40.
- Redirect coincident with imem_rvalid (ex_bs=11, ex_pc=3, ex_imm=4) -> data dropped, next imem_addr=8.
- pc=0xFFFFFFFF fetch -> next imem_addr=0; rst pulsed while in DROP -> outputs at reset values, a late rvalid is ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode fields, branch-select encodings, the NOP
// word and the fetch-unit state encoding.
package cpu_pkg;

    // Opcode field position and the opcodes the front end knows by name
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 25;
    localparam logic [6:0] OP_NOP = 7'h00;
    localparam logic [6:0] OP_ADD = 7'h02;
    localparam logic [6:0] OP_BZ  = 7'h20;
    localparam logic [6:0] OP_JMR = 7'h21;
    localparam logic [6:0] OP_JMP = 7'h22;

    // Branch-select (BS) encodings produced by the decoder
    localparam logic [1:0] BS_NEXT   = 2'b00;
    localparam logic [1:0] BS_BRANCH = 2'b01;
    localparam logic [1:0] BS_JMR    = 2'b10;
    localparam logic [1:0] BS_JUMP   = 2'b11;

    // All-zero word decodes as a no-operation
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        START,
        REQ,
        WAIT,
        DROP,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/next_pc_unit.sv
// Combinational next-PC selection: decides whether the executing instruction
// redirects the front end and computes the resulting fetch address.
module next_pc_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  advance_i,
    input  logic                  ex_valid_i,
    input  logic [1:0]            ex_bs_i,
    input  logic                  ex_ps_i,
    input  logic                  ex_z_i,
    input  logic [ADDR_WIDTH-1:0] ex_pc_i,
    input  logic [ADDR_WIDTH-1:0] ex_imm_i,
    input  logic [ADDR_WIDTH-1:0] ex_reg_a_i,
    output logic                  redirect_o,
    output logic [ADDR_WIDTH-1:0] target_o,
    output logic [ADDR_WIDTH-1:0] next_pc_o
);
    import cpu_pkg::*;

    // Redirect decision and target; a redirect always wins over sequential advance
    always_comb begin
        redirect_o = 1'b0;
        target_o   = ex_pc_i + ADDR_WIDTH'(1) + ex_imm_i;
        if (ex_valid_i) begin
            case (ex_bs_i)
                BS_BRANCH: redirect_o = ex_z_i ^ ex_ps_i;
                BS_JMR: begin
                    redirect_o = 1'b1;
                    target_o   = ex_reg_a_i;
                end
                BS_JUMP:   redirect_o = 1'b1;
                default:   redirect_o = 1'b0;
            endcase
        end
        if (redirect_o)
            next_pc_o = target_o;
        else if (advance_i)
            next_pc_o = pc_i + ADDR_WIDTH'(1);
        else
            next_pc_o = pc_i;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: one outstanding request to instruction memory,
// one instruction slot towards the decoder, PC redirect on taken branches.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                  INSTRUCTION_SIZE = 32,
    parameter int                  ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [ADDR_WIDTH-1:0]       imem_addr,
    input  logic                        imem_ready,
    input  logic                        imem_rvalid,
    input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic                        instr_valid,
    output logic [ADDR_WIDTH-1:0]       instr_pc,
    input  logic                        stall,
    input  logic                        ex_valid,
    input  logic [1:0]                  ex_bs,
    input  logic                        ex_ps,
    input  logic                        ex_z,
    input  logic [ADDR_WIDTH-1:0]       ex_pc,
    input  logic [ADDR_WIDTH-1:0]       ex_imm,
    input  logic [ADDR_WIDTH-1:0]       ex_reg_a
);

    fetch_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]       pc_q, pc_d;
    logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]       instr_pc_q, instr_pc_d;
    logic                        valid_q, valid_d;
    logic                        redirect;
    logic [ADDR_WIDTH-1:0]       target;
    logic                        advance;

    // The PC only advances when the memory accepts the current request
    assign advance = (state_q == REQ) && imem_ready;

    next_pc_unit #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_next_pc (
        .pc_i      (pc_q),
        .advance_i (advance),
        .ex_valid_i(ex_valid),
        .ex_bs_i   (ex_bs),
        .ex_ps_i   (ex_ps),
        .ex_z_i    (ex_z),
        .ex_pc_i   (ex_pc),
        .ex_imm_i  (ex_imm),
        .ex_reg_a_i(ex_reg_a),
        .redirect_o(redirect),
        .target_o  (target),
        .next_pc_o (pc_d)
    );

    // Fetch sequencing: request, wait/drop the response, hold the slot for decode
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        case (state_q)
            START: state_d = REQ;
            REQ: begin
                // An accept coinciding with a redirect leaves a response to discard
                if (redirect)
                    state_d = imem_ready ? DROP : REQ;
                else if (imem_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q - ADDR_WIDTH'(1);
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
            end
            DROP: begin
                if (imem_rvalid)
                    state_d = REQ;
            end
            HOLD: begin
                if (redirect || !stall) begin
                    valid_d = 1'b0;
                    instr_d = INSTRUCTION_SIZE'(NOP_WORD);
                    state_d = REQ;
                end
            end
            default: state_d = START;
        endcase
    end

    // State, PC and instruction slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            instr_q    <= INSTRUCTION_SIZE'(NOP_WORD);
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: randomized memory latency,
// back-pressure and branch traffic checked against a transaction-level model.
module tb_instruction_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        stall;
    logic        ex_valid;
    logic [1:0]  ex_bs;
    logic        ex_ps;
    logic        ex_z;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_reg_a;

    always #5 clk = ~clk;

    instruction_fetch #(
        .INSTRUCTION_SIZE(32),
        .ADDR_WIDTH(32),
        .RESET_PC(32'd0)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .stall(stall), .ex_valid(ex_valid), .ex_bs(ex_bs), .ex_ps(ex_ps), .ex_z(ex_z),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_reg_a(ex_reg_a)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus knobs (percentages / max latency)
    int p_ready = 100, p_stall = 0, p_branch = 0, p_stale = 0, max_lat = 1;
    bit const_data = 1'b1;

    // One-shot branch override for directed cases
    bit          ovr_en = 1'b0;
    logic [1:0]  ovr_bs;
    logic        ovr_ps, ovr_z;
    logic [31:0] ovr_pc, ovr_imm, ovr_reg_a;

    // Reference model: architectural fetch PC, the decoder slot, and the single
    // outstanding memory transaction (killed by any later redirect)
    logic [31:0] exp_pc, exp_instr, exp_ipc, out_addr;
    bit          exp_valid, out_pend, out_live, stale_pend, in_start;
    int          out_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (const_data) return 32'h0442_0000;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    function automatic bit mdl_req();
        return !in_start && !out_pend && !exp_valid;
    endfunction

    // One clock cycle: check outputs, drive new inputs, advance the model
    task automatic step();
        bit          redirect, accept, deliver, exp_req;
        logic [31:0] target;
        exp_req = mdl_req();
        check_val("req", imem_req, exp_req);
        if (exp_req) check_val("addr", imem_addr, exp_pc);
        check_val("valid", instr_valid, exp_valid);
        check_val("instr", instruction, exp_valid ? exp_instr : 32'h0);
        if (exp_valid) check_val("ipc", instr_pc, exp_ipc);

        stall    = pct(p_stall);
        ex_valid = !in_start && pct(p_branch);
        ex_bs    = 2'($urandom_range(0, 3));
        ex_ps    = 1'($urandom_range(0, 1));
        ex_z     = 1'($urandom_range(0, 1));
        ex_pc    = pct(50) ? 32'($urandom_range(0, 64)) : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        ex_imm   = 32'($urandom_range(0, 15)) - 32'd8;
        ex_reg_a = pct(30) ? 32'hFFFF_FFFE : $urandom;
        if (ovr_en) begin
            ex_valid = 1'b1; ex_bs = ovr_bs; ex_ps = ovr_ps; ex_z = ovr_z;
            ex_pc = ovr_pc; ex_imm = ovr_imm; ex_reg_a = ovr_reg_a;
            ovr_en = 1'b0;
        end
        imem_ready = pct(p_ready);

        deliver = 1'b0;
        if (out_pend) begin
            out_lat--;
            deliver = (out_lat == 0);
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (deliver) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(out_addr);
        end else if (!out_pend && stale_pend && pct(50)) begin
            imem_rvalid = 1'b1;
            stale_pend  = 1'b0;
        end else if (!out_pend && pct(p_stale)) begin
            imem_rvalid = 1'b1;
        end

        redirect = 1'b0;
        target   = ex_pc + 32'd1 + ex_imm;
        if (ex_valid) begin
            if (ex_bs == 2'b01 && (ex_z ^ ex_ps)) redirect = 1'b1;
            if (ex_bs == 2'b10) begin redirect = 1'b1; target = ex_reg_a; end
            if (ex_bs == 2'b11) redirect = 1'b1;
        end
        accept = exp_req && imem_ready;

        if (deliver && out_live && !redirect) begin
            exp_valid = 1'b1;
            exp_instr = mem_word(out_addr);
            exp_ipc   = out_addr;
        end else if (!(exp_valid && stall && !redirect)) begin
            exp_valid = 1'b0;
        end
        if (deliver) out_pend = 1'b0;
        if (accept) begin
            out_pend = 1'b1;
            out_live = 1'b1;
            out_addr = exp_pc;
            out_lat  = $urandom_range(1, max_lat);
        end
        if (redirect) out_live = 1'b0;
        if (redirect)    exp_pc = target;
        else if (accept) exp_pc = exp_pc + 32'd1;
        in_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_idle();
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; stall = 1'b0;
        ex_valid = 1'b0; ex_bs = 2'b00; ex_ps = 1'b0; ex_z = 1'b0;
        ex_pc = '0; ex_imm = '0; ex_reg_a = '0;
    endtask

    // Asynchronous reset pulse starting between clock edges
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_req", imem_req, 1'b0);
        check_val("rst_addr", imem_addr, 32'd0);
        check_val("rst_instr", instruction, 32'd0);
        check_val("rst_valid", instr_valid, 1'b0);
        check_val("rst_ipc", instr_pc, 32'd0);
        drive_idle();
        if (out_pend) stale_pend = 1'b1;
        exp_pc = 32'd0; exp_valid = 1'b0; exp_instr = '0; exp_ipc = '0;
        out_pend = 1'b0; out_live = 1'b0; out_lat = 0;
        @(negedge clk);
        rst = 1'b0;
        in_start = 1'b1;
    endtask

    task automatic run_until_req(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (mdl_req()) ok = 1'b1;
            else step();
        end
        check_val(tag, ok, 1'b1);
    endtask

    task automatic run_until_valid(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (exp_valid) ok = 1'b1;
            else step();
        end
        check_val(tag, ok, 1'b1);
    endtask

    // Advance until a live fetch is outstanding with the given remaining latency
    task automatic run_until_wait(input string tag, input int lat_min, input int lat_max);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (out_pend && out_live && out_lat >= lat_min && out_lat <= lat_max) ok = 1'b1;
            else step();
        end
        check_val(tag, ok, 1'b1);
    endtask

    logic [31:0] saved_instr, saved_ipc;

    initial begin
        rst = 1'b1;
        drive_idle();
        stale_pend = 1'b0;
        in_start   = 1'b0;
        exp_pc = '0; exp_valid = 1'b0; exp_instr = '0; exp_ipc = '0;
        out_pend = 1'b0; out_live = 1'b0; out_lat = 0; out_addr = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Zero-wait memory, constant data: requests at 0,1,2, NOP between slots
        for (int k = 0; k < 3; k++) begin
            run_until_req("seq_find_req");
            check_val("seq_addr", imem_addr, 32'(k));
            step();
            step();
            check_val("seq_valid", instr_valid, 1'b1);
            check_val("seq_instr", instruction, 32'h0442_0000);
            check_val("seq_ipc", instr_pc, 32'(k));
            step();
            check_val("seq_nop", instruction, 32'd0);
            check_val("seq_req3", imem_req, 1'b1);
        end
        const_data = 1'b0;

        // Decode stall holds the slot and blocks further requests
        p_stall = 100;
        run_until_valid("stall_find");
        saved_instr = instruction;
        saved_ipc   = instr_pc;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("stall_instr", instruction, saved_instr);
            check_val("stall_ipc", instr_pc, saved_ipc);
            check_val("stall_noreq", imem_req, 1'b0);
        end
        p_stall = 0;
        run_until_req("stall_find_req");
        check_val("stall_next_addr", imem_addr, saved_ipc + 32'd1);

        // Taken conditional branch while waiting: 10 + 1 - 3 = 8
        max_lat = 3;
        run_until_wait("wait_find", 2, 3);
        ovr_en = 1'b1; ovr_bs = BS_BRANCH; ovr_ps = 1'b0; ovr_z = 1'b1;
        ovr_pc = 32'd10; ovr_imm = 32'hFFFF_FFFD; ovr_reg_a = '0;
        step();
        run_until_req("br_find_req");
        check_val("br_target", imem_addr, 32'd8);

        // Not-taken branch (PS=1, Z=1) keeps sequential fetch
        run_until_wait("nt_find", 1, 3);
        saved_ipc = out_addr;
        ovr_en = 1'b1; ovr_bs = BS_BRANCH; ovr_ps = 1'b1; ovr_z = 1'b1;
        ovr_pc = 32'd100; ovr_imm = 32'd50; ovr_reg_a = '0;
        step();
        run_until_valid("nt_valid");
        check_val("nt_ipc", instr_pc, saved_ipc);

        // JMR while an instruction is held
        p_stall = 100;
        run_until_valid("jmr_find");
        ovr_en = 1'b1; ovr_bs = BS_JMR; ovr_ps = 1'b0; ovr_z = 1'b0;
        ovr_pc = 32'd0; ovr_imm = 32'd0; ovr_reg_a = 32'h40;
        step();
        check_val("jmr_inval", instr_valid, 1'b0);
        p_stall = 0;
        run_until_req("jmr_find_req");
        check_val("jmr_target", imem_addr, 32'h40);

        // Jump coincident with the response: 3 + 1 + 4 = 8
        run_until_wait("coin_find", 1, 1);
        ovr_en = 1'b1; ovr_bs = BS_JUMP; ovr_ps = 1'b0; ovr_z = 1'b0;
        ovr_pc = 32'd3; ovr_imm = 32'd4; ovr_reg_a = '0;
        step();
        check_val("coin_novalid", instr_valid, 1'b0);
        check_val("coin_req", imem_req, 1'b1);
        check_val("coin_target", imem_addr, 32'd8);

        // Fetch at the top of the address space wraps to 0
        max_lat = 1;
        run_until_req("wrap_find0");
        ovr_en = 1'b1; ovr_bs = BS_JMR; ovr_ps = 1'b0; ovr_z = 1'b0;
        ovr_pc = 32'd0; ovr_imm = 32'd0; ovr_reg_a = 32'hFFFF_FFFF;
        step();
        run_until_req("wrap_find1");
        check_val("wrap_addr_top", imem_addr, 32'hFFFF_FFFF);
        step();
        run_until_valid("wrap_valid");
        check_val("wrap_ipc", instr_pc, 32'hFFFF_FFFF);
        run_until_req("wrap_find2");
        check_val("wrap_addr_zero", imem_addr, 32'd0);

        // Reset while dropping a response; the late response must be ignored
        max_lat = 4;
        run_until_wait("drop_find", 2, 4);
        ovr_en = 1'b1; ovr_bs = BS_JUMP; ovr_ps = 1'b0; ovr_z = 1'b0;
        ovr_pc = 32'd20; ovr_imm = 32'd5; ovr_reg_a = '0;
        step();
        do_reset();
        p_ready = 0;
        for (int i = 0; i < 4; i++) step();
        check_val("drop_rst_noval", instr_valid, 1'b0);
        check_val("drop_rst_addr", imem_addr, 32'd0);
        p_ready = 100;
        run_until_req("drop_rst_req");
        check_val("drop_rst_restart", imem_addr, 32'd0);

        // Randomized traffic with occasional resets
        p_ready = 60; p_stall = 30; p_branch = 25; p_stale = 5; max_lat = 4;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
